// File: rtl/rv32_mem_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// Data has priority, fetch is forced after STARVE_LIMIT back-to-back data grants.
module rv32_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read_in,
  input  logic [31:0] instr_address_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_address_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic        bus_error_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_address_out,
  output logic [31:0] mem_write_value_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in
);

  typedef enum logic [1:0] {IDLE, BUSY_INSTR, BUSY_DATA} state_t;

  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);

  state_t      state, state_next;
  logic [31:0] starve_count, starve_count_next;
  logic [31:0] timer, timer_next;
  logic        data_req, busy, timeout, finish;
  logic        grant_data, grant_instr;

  always_comb begin
    data_req    = data_read_in | data_write_in;
    busy        = (state != IDLE);
    timeout     = WDOG_EN && busy && !mem_ready_in && (timer == 32'(TIMEOUT_CYCLES));
    finish      = busy && (mem_ready_in || timeout);
    // Fetch overrides data only once the starvation budget is spent.
    grant_data  = (state == IDLE) && data_req &&
                  !(instr_read_in && (starve_count >= 32'(STARVE_LIMIT)));
    grant_instr = (state == IDLE) && instr_read_in && !grant_data;
  end

  always_comb begin
    state_next        = state;
    starve_count_next = starve_count;
    timer_next        = timer;
    case (state)
      IDLE: begin
        if (grant_data) begin
          state_next        = BUSY_DATA;
          timer_next        = '0;
          starve_count_next = instr_read_in ? starve_count + 32'd1 : '0;
        end else if (grant_instr) begin
          state_next        = BUSY_INSTR;
          timer_next        = '0;
          starve_count_next = '0;
        end
      end
      default: begin
        if (finish) begin
          state_next = IDLE;
        end else if (WDOG_EN) begin
          timer_next = timer + 32'd1;
        end
      end
    endcase
  end

  always_comb begin
    instr_ready_out      = (state == BUSY_INSTR) && finish;
    data_ready_out       = (state == BUSY_DATA) && finish;
    bus_error_out        = timeout;
    instr_read_value_out = ((state == BUSY_INSTR) && mem_ready_in) ? mem_read_value_in : '0;
    data_read_value_out  = ((state == BUSY_DATA) && mem_ready_in) ? mem_read_value_in : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      starve_count        <= '0;
      timer               <= '0;
      mem_read_out        <= 1'b0;
      mem_write_out       <= 1'b0;
      mem_write_mask_out  <= '0;
      mem_address_out     <= '0;
      mem_write_value_out <= '0;
    end else begin
      state        <= state_next;
      starve_count <= starve_count_next;
      timer        <= timer_next;
      if (grant_data) begin
        // A simultaneous read and write is issued as a write.
        mem_read_out        <= data_read_in & ~data_write_in;
        mem_write_out       <= data_write_in;
        mem_write_mask_out  <= data_write_mask_in;
        mem_address_out     <= data_address_in;
        mem_write_value_out <= data_write_value_in;
      end else if (grant_instr) begin
        mem_read_out        <= 1'b1;
        mem_write_out       <= 1'b0;
        mem_write_mask_out  <= '0;
        mem_address_out     <= instr_address_in;
      end else if (finish) begin
        mem_read_out        <= 1'b0;
        mem_write_out       <= 1'b0;
        mem_write_mask_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: per-cycle vector table plus hand-written
// sequences for contention, watchdog, timeout tie and reset during a transaction.
module tb_rv32_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        instr_read_in;
  logic [31:0] instr_address_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_address_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic        bus_error_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [3:0]  mem_write_mask_out;
  logic [31:0] mem_address_out;
  logic [31:0] mem_write_value_out;
  logic [31:0] mem_read_value_in;
  logic        mem_ready_in;

  int checks   = 0;
  int failures = 0;

  rv32_mem_arbiter #(.STARVE_LIMIT(2), .TIMEOUT_CYCLES(5)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_read_in        (instr_read_in),
    .instr_address_in     (instr_address_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_address_in      (data_address_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .bus_error_out        (bus_error_out),
    .mem_read_out         (mem_read_out),
    .mem_write_out        (mem_write_out),
    .mem_write_mask_out   (mem_write_mask_out),
    .mem_address_out      (mem_address_out),
    .mem_write_value_out  (mem_write_value_out),
    .mem_read_value_in    (mem_read_value_in),
    .mem_ready_in         (mem_ready_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required finish");
    $fatal(1, "bench time limit expired");
  end

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [3:0]  dm;
    logic [31:0] da;
    logic [31:0] dv;
    logic [31:0] mrd;
    logic        mry;
    logic        e_ir;
    logic [31:0] e_iv;
    logic        e_dr;
    logic [31:0] e_dv;
    logic        e_be;
    logic        e_mr;
    logic        e_mw;
    logic [3:0]  e_mm;
    logic [31:0] e_ma;
    logic [31:0] e_mv;
  } vec_t;

  vec_t vecs[16];

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    reset               = 1'b0;
    instr_read_in       = 1'b0;
    instr_address_in    = '0;
    data_read_in        = 1'b0;
    data_write_in       = 1'b0;
    data_write_mask_in  = '0;
    data_address_in     = '0;
    data_write_value_in = '0;
    mem_read_value_in   = '0;
    mem_ready_in        = 1'b0;
  endtask

  // One contended grant: an IDLE cycle followed by a zero-wait busy cycle.
  task automatic grant_pair(input string tag, input bit exp_data, input logic [31:0] exp_addr);
    #1;
    chk({tag, ".idle_iready"}, 32'(instr_ready_out), 32'd0);
    chk({tag, ".idle_dready"}, 32'(data_ready_out), 32'd0);
    cyc();
    #1;
    chk({tag, ".dready"}, 32'(data_ready_out), 32'(exp_data));
    chk({tag, ".iready"}, 32'(instr_ready_out), 32'(!exp_data));
    chk({tag, ".addr"}, mem_address_out, exp_addr);
    $display("%s: grant %s addr 0x%08h", tag, exp_data ? "DATA " : "INSTR", mem_address_out);
    cyc();
  endtask

  initial begin
    bit order[6];
    vec_t v;

    // rst ir ia  dr dw dm da dv mrd mry | e_ir e_iv e_dr e_dv e_be e_mr e_mw e_mm e_ma e_mv
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 32'h100, 0, 0, 0, 0, 0, 32'h11111111, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 32'h100, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1,
                 1, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 32'h100, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0};
    vecs[4]  = '{0, 0, 0, 0, 1, 4'b0100, 32'h2002, 32'h00AB0000, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0};
    vecs[5]  = '{0, 0, 0, 0, 1, 4'b0100, 32'h2002, 32'h00AB0000, 0, 0,
                 0, 0, 0, 0, 0, 0, 1, 4'b0100, 32'h2002, 32'h00AB0000};
    vecs[6]  = vecs[5];
    vecs[7]  = vecs[5];
    vecs[8]  = '{0, 0, 0, 0, 1, 4'b0100, 32'h2002, 32'h00AB0000, 32'h12345678, 1,
                 0, 0, 1, 32'h12345678, 0, 0, 1, 4'b0100, 32'h2002, 32'h00AB0000};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 32'h2002, 32'h00AB0000};
    vecs[10] = '{0, 0, 0, 1, 1, 4'hF, 32'h300, 32'h55AA55AA, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 32'h2002, 32'h00AB0000};
    vecs[11] = '{0, 0, 0, 1, 1, 4'hF, 32'h300, 32'h55AA55AA, 32'h0BADF00D, 1,
                 0, 0, 1, 32'h0BADF00D, 0, 0, 1, 4'hF, 32'h300, 32'h55AA55AA};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 32'h300, 32'h55AA55AA};
    vecs[13] = '{0, 0, 0, 1, 0, 0, 32'h400, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 32'h300, 32'h55AA55AA};
    vecs[14] = '{0, 0, 0, 1, 0, 0, 32'h400, 0, 32'hCAFEF00D, 1,
                 0, 0, 1, 32'hCAFEF00D, 0, 1, 0, 0, 32'h400, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 32'h400, 0};

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      reset               = v.rst;
      instr_read_in       = v.ir;
      instr_address_in    = v.ia;
      data_read_in        = v.dr;
      data_write_in       = v.dw;
      data_write_mask_in  = v.dm;
      data_address_in     = v.da;
      data_write_value_in = v.dv;
      mem_read_value_in   = v.mrd;
      mem_ready_in        = v.mry;
      #1;
      chk($sformatf("v%0d.instr_ready", i), 32'(instr_ready_out), 32'(v.e_ir));
      chk($sformatf("v%0d.instr_value", i), instr_read_value_out, v.e_iv);
      chk($sformatf("v%0d.data_ready", i), 32'(data_ready_out), 32'(v.e_dr));
      chk($sformatf("v%0d.data_value", i), data_read_value_out, v.e_dv);
      chk($sformatf("v%0d.bus_error", i), 32'(bus_error_out), 32'(v.e_be));
      chk($sformatf("v%0d.mem_read", i), 32'(mem_read_out), 32'(v.e_mr));
      chk($sformatf("v%0d.mem_write", i), 32'(mem_write_out), 32'(v.e_mw));
      chk($sformatf("v%0d.mem_mask", i), 32'(mem_write_mask_out), 32'(v.e_mm));
      chk($sformatf("v%0d.mem_addr", i), mem_address_out, v.e_ma);
      chk($sformatf("v%0d.mem_wval", i), mem_write_value_out, v.e_mv);
      $display("vector %0d: ir=%0b dr=%0b dw=%0b mry=%0b -> iready=%0b dready=%0b mr=%0b mw=%0b addr=0x%08h",
               i, v.ir, v.dr, v.dw, v.mry, instr_ready_out, data_ready_out,
               mem_read_out, mem_write_out, mem_address_out);
      cyc();
    end

    // Contention with STARVE_LIMIT=2 and zero-wait memory.
    clear_inputs();
    instr_read_in     = 1'b1;
    instr_address_in  = 32'h500;
    data_read_in      = 1'b1;
    data_address_in   = 32'h600;
    mem_ready_in      = 1'b1;
    mem_read_value_in = 32'h77;
    order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int g = 0; g < 6; g++) begin
      grant_pair($sformatf("contend%0d", g), order[g], order[g] ? 32'h600 : 32'h500);
    end

    // Watchdog: no mem_ready, abort after timer reaches 5.
    clear_inputs();
    data_read_in      = 1'b1;
    data_address_in   = 32'h700;
    mem_read_value_in = 32'h99;
    #1;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("wdog%0d.dready", k), 32'(data_ready_out), 32'(k == 6));
      chk($sformatf("wdog%0d.berr", k), 32'(bus_error_out), 32'(k == 6));
      chk($sformatf("wdog%0d.dvalue", k), data_read_value_out, 32'd0);
      chk($sformatf("wdog%0d.mem_read", k), 32'(mem_read_out), 32'd1);
      if (k == 6) begin
        $display("watchdog: abort in busy cycle %0d, bus_error=%0b", k, bus_error_out);
        data_read_in = 1'b0;
      end
      cyc();
    end
    #1;
    chk("wdog.after_mem_read", 32'(mem_read_out), 32'd0);
    chk("wdog.after_dready", 32'(data_ready_out), 32'd0);
    chk("wdog.after_berr", 32'(bus_error_out), 32'd0);

    // Timeout tie: mem_ready arrives exactly in the timeout cycle.
    clear_inputs();
    data_read_in    = 1'b1;
    data_address_in = 32'h800;
    #1;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin
        mem_ready_in      = 1'b1;
        mem_read_value_in = 32'hABCD;
      end
      #1;
      chk($sformatf("tie%0d.dready", k), 32'(data_ready_out), 32'(k == 6));
      chk($sformatf("tie%0d.berr", k), 32'(bus_error_out), 32'd0);
      chk($sformatf("tie%0d.dvalue", k), data_read_value_out, (k == 6) ? 32'hABCD : 32'd0);
      if (k == 6) begin
        $display("tie: completion in busy cycle %0d, bus_error=%0b", k, bus_error_out);
        clear_inputs();
      end
      cyc();
    end
    #1;
    chk("tie.after_mem_read", 32'(mem_read_out), 32'd0);

    // Reset mid-transaction after two data grants have consumed the starve budget.
    clear_inputs();
    instr_read_in       = 1'b1;
    instr_address_in    = 32'h500;
    data_write_in       = 1'b1;
    data_address_in     = 32'h900;
    data_write_value_in = 32'h11;
    data_write_mask_in  = 4'b0011;
    mem_ready_in        = 1'b1;
    grant_pair("pre_reset", 1'b1, 32'h900);
    cyc();
    mem_ready_in = 1'b0;
    #1;
    chk("rst.busy_mem_write", 32'(mem_write_out), 32'd1);
    chk("rst.busy_addr", mem_address_out, 32'h900);
    chk("rst.busy_dready", 32'(data_ready_out), 32'd0);
    reset = 1'b1;
    cyc();
    reset        = 1'b0;
    mem_ready_in = 1'b1;
    #1;
    chk("rst.mem_read", 32'(mem_read_out), 32'd0);
    chk("rst.mem_write", 32'(mem_write_out), 32'd0);
    chk("rst.mem_mask", 32'(mem_write_mask_out), 32'd0);
    chk("rst.mem_addr", mem_address_out, 32'd0);
    chk("rst.mem_wval", mem_write_value_out, 32'd0);
    chk("rst.dready", 32'(data_ready_out), 32'd0);
    chk("rst.iready", 32'(instr_ready_out), 32'd0);
    $display("reset: aborted busy data transaction");
    grant_pair("post_reset0", 1'b1, 32'h900);
    grant_pair("post_reset1", 1'b1, 32'h900);
    grant_pair("post_reset2", 1'b0, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one external memory port between the instruction-fetch bus and the data-memory bus driven by the memory-access stage.
- Sequences one transaction at a time through a 3-state FSM.
- Returns per-requester ready pulses, which the hazard unit uses as stall release.
- Data has priority; a starvation limit guarantees fetch progress; an optional watchdog terminates hung transactions.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced (must be ≥1)
TIMEOUT_CYCLES, 0, busy cycles without mem_ready_in before forced abort; 0 disables the watchdog

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instr_read_in  in  1  fetch request, held until instr_ready_out
instr_address_in  in  32  fetch address
instr_read_value_out  out  32  fetch data, valid when instr_ready_out
instr_ready_out  out  1  fetch complete, one-cycle pulse
data_read_in  in  1  data read request, held until data_ready_out
data_write_in  in  1  data write request, held until data_ready_out
data_write_mask_in  in  4  byte-lane write mask
data_address_in  in  32  data address
data_write_value_in  in  32  write data
data_read_value_out  out  32  read data, valid when data_ready_out
data_ready_out  out  1  data access complete, one-cycle pulse
bus_error_out  out  1  pulses with ready when a transaction is aborted by the watchdog
mem_read_out  out  1  memory read strobe (registered)
mem_write_out  out  1  memory write strobe (registered)
mem_write_mask_out  out  4  memory byte mask (registered)
mem_address_out  out  32  memory address (registered)
mem_write_value_out  out  32  memory write data (registered)
mem_read_value_in  in  32  memory read data
mem_ready_in  in  1  memory completes the current access this cycle

Behaviour:
- Reset: state IDLE, starve_count=0, timer=0; all mem_* outputs 0; ready/error outputs 0.
- FSM states: IDLE, BUSY_INSTR, BUSY_DATA.
- Data request = data_read_in | data_write_in. If both are set, the write wins: mem_write_out=1, mem_read_out=0.
- IDLE arbitration, evaluated each cycle:
  - Data only → BUSY_DATA.
  - Instr only → BUSY_INSTR.
  - Both, starve_count<STARVE_LIMIT → BUSY_DATA, starve_count+1.
  - Both, starve_count==STARVE_LIMIT → BUSY_INSTR.
  - Any BUSY_INSTR grant clears starve_count. A data grant with no instr pending also clears it.
- On a grant at edge N, mem_* outputs are latched from the winner's inputs and valid from cycle N+1.
  - Instr grant: mem_read_out=1, mem_write_out=0, mask=0.
  - Data grant: strobes and mask copied from the data inputs.
- Busy phase: mem_* outputs are held constant; requester inputs are not re-sampled.
- Completion: in a BUSY cycle with mem_ready_in=1, the owner's ready_out=1 in that same cycle (combinational), and its read_value_out=mem_read_value_in.
  - At the following edge: state→IDLE, mem strobes→0, mask→0; address and write value hold.
- Minimum latency is 2 cycles from request to ready: request cycle N, ready cycle N+1 when memory is zero-wait.
- A new grant requires one IDLE cycle after each completion; peak throughput is 1 access per 2 cycles.
- Ready for the non-owner is always 0. read_value outputs are 0 when the corresponding ready is 0.
- mem_ready_in is ignored in IDLE.
- Watchdog (TIMEOUT_CYCLES>0):
  - timer clears on grant and increments each BUSY cycle without mem_ready_in.
  - When timer==TIMEOUT_CYCLES and mem_ready_in=0, the owner's ready and bus_error_out pulse, read value=0, and state→IDLE at the next edge.
  - mem_ready_in in the same cycle wins over the timeout, giving normal completion.
- Request withdrawn during BUSY: illegal, but the transaction still completes and the ready pulse is still issued.
- Reset during BUSY: abort immediately at the edge; no ready pulse is issued. The transaction in flight is the memory's responsibility.

Test Plan:
- Zero-wait fetch: instr_read_in=1, addr 0x100, mem_ready_in high from cycle 1 with data 0xDEADBEEF → mem_read_out=1 and address 0x100 in cycle 1; instr_ready_out pulse in cycle 1 with value 0xDEADBEEF; mem_read_out=0 in cycle 2.
- Data write with 3 wait states: data_write_in=1, mask 0b0100, addr 0x2002, value 0x00AB0000 → strobes, mask and value stable for 4 cycles; single data_ready_out pulse on the 4th; instr_ready_out stays 0.
- Contention with STARVE_LIMIT=2: both requests held continuously, zero-wait memory → grant order DATA, DATA, INSTR, DATA, DATA, INSTR; exactly one ready pulse per grant.
- Watchdog with TIMEOUT_CYCLES=5: data read, mem_ready_in held 0 → data_ready_out and bus_error_out pulse 5 busy cycles after the grant; data_read_value_out=0; FSM returns to IDLE.
- Timeout tie: mem_ready_in rises exactly in the timeout cycle → normal completion, bus_error_out=0.
- Reset mid-transaction: assert reset during BUSY_DATA → all mem_* are 0 after the edge, no ready pulse, starve_count=0; the next request is granted normally.
